// File: rtl/cic_comp_pkg.sv
// Shared constants, FSM encoding, coefficient set and saturation helper for cic_comp_fir.
package cic_comp_pkg;

    localparam int unsigned BITS_DEFAULT      = 16;
    localparam int unsigned TAPS_DEFAULT      = 32;
    localparam int unsigned COEF_BITS_DEFAULT = 16;
    localparam int unsigned ACC_BITS_DEFAULT  = 40;
    localparam int unsigned DECIM_DEFAULT     = 2;

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    typedef logic signed [COEF_BITS_DEFAULT-1:0] coef_t;

    // CIC^5 inverse-sinc compensator, cutoff 0.2*fs_in, Q1.15, symmetric, sum = 32768 (unity DC gain)
    localparam coef_t COEFS [TAPS_DEFAULT] = '{
        -16'sd40,   -16'sd60,    16'sd30,    16'sd150,
         16'sd120,  -16'sd200,  -16'sd420,  -16'sd80,
         16'sd700,   16'sd900,  -16'sd250,  -16'sd1700,
        -16'sd1400,  16'sd1700,  16'sd6500,  16'sd10434,
         16'sd10434, 16'sd6500,  16'sd1700, -16'sd1400,
        -16'sd1700, -16'sd250,   16'sd900,   16'sd700,
        -16'sd80,   -16'sd420,  -16'sd200,   16'sd120,
         16'sd150,   16'sd30,   -16'sd60,   -16'sd40
    };

    // Clamp a wide signed value into the signed range of a 'bits'-wide word
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned        bits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/cic_comp_fir_rom.sv
// Synchronous-read coefficient ROM; data_o holds COEFS[addr_i] from the previous clock.
module fir_coef_rom
    import cic_comp_pkg::*;
#(
    parameter int unsigned TAPS      = TAPS_DEFAULT,
    parameter int unsigned COEF_BITS = COEF_BITS_DEFAULT
) (
    input  logic                        clk_i,
    input  logic [$clog2(TAPS)-1:0]     addr_i,
    output logic signed [COEF_BITS-1:0] data_o
);

    logic signed [COEF_BITS-1:0] data_q;

    // Registered read, maps to block RAM or LUT ROM
    always_ff @(posedge clk_i) begin
        data_q <= COEF_BITS'(COEFS[addr_i]);
    end

    assign data_o = data_q;

endmodule

// File: rtl/cic_comp_fir.sv
// Decimate-by-DECIM CIC compensation FIR with a single time-shared MAC.
// out_tick follows the triggering in_tick by exactly TAPS+3 cycles (multiplier not pipelined).
// The coefficient ROM is addressed with the next tap index so its registered output lines up
// with the current tap, adding no latency.
module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter int unsigned BITS      = BITS_DEFAULT,
    parameter int unsigned TAPS      = TAPS_DEFAULT,
    parameter int unsigned COEF_BITS = COEF_BITS_DEFAULT,
    parameter int unsigned ACC_BITS  = ACC_BITS_DEFAULT,
    parameter int unsigned DECIM     = DECIM_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic signed [BITS-1:0] x_in,
    input  logic                   in_tick,
    output logic signed [BITS-1:0] x_out,
    output logic                   out_tick,
    output logic                   overrun
);

    localparam int unsigned KW     = $clog2(TAPS);
    localparam int unsigned PW     = KW + 1;
    localparam int unsigned FW     = KW + 1;
    localparam int unsigned PHW    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned PROD_W = BITS + COEF_BITS;
    localparam logic signed [ACC_BITS-1:0] RND_HALF = ACC_BITS'(1) << (COEF_BITS - 2);

    logic [1:0]                  state_q,    state_d;
    logic [PW-1:0]               wr_ptr_q,   wr_ptr_d;
    logic [PHW-1:0]              phase_q,    phase_d;
    logic [FW-1:0]               fill_q,     fill_d;
    logic [FW-1:0]               nvalid_q,   nvalid_d;
    logic [PW-1:0]               base_q,     base_d;
    logic [KW-1:0]               k_q,        k_d;
    logic signed [ACC_BITS-1:0]  acc_q,      acc_d;
    logic signed [BITS-1:0]      rnd_q,      rnd_d;
    logic signed [BITS-1:0]      x_out_q,    x_out_d;
    logic                        out_tick_q, out_tick_d;
    logic                        overrun_q,  overrun_d;

    logic signed [BITS-1:0]      samp_mem [2*TAPS];
    logic [PW-1:0]               rd_addr;
    logic signed [BITS-1:0]      samp_rd;
    logic signed [BITS-1:0]      samp_use;
    logic signed [COEF_BITS-1:0] coef_rd;
    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_BITS-1:0]  prod_ext;
    logic signed [ACC_BITS-1:0]  rsum;
    logic signed [ACC_BITS-1:0]  rshift;
    logic                        trig;

    fir_coef_rom #(
        .TAPS      (TAPS),
        .COEF_BITS (COEF_BITS)
    ) u_rom (
        .clk_i  (CLK),
        .addr_i (k_d),
        .data_o (coef_rd)
    );

    // Sample buffer write port; a sample coinciding with RST is discarded
    always_ff @(posedge CLK) begin
        if (!RST && in_tick) begin
            samp_mem[wr_ptr_q] <= x_in;
        end
    end

    // Datapath: newest-first tap read, samples older than the fill count read as zero
    assign trig     = in_tick && (phase_q == PHW'(DECIM - 1));
    assign rd_addr  = base_q - PW'(k_q);
    assign samp_rd  = samp_mem[rd_addr];
    assign samp_use = (FW'(k_q) < nvalid_q) ? samp_rd : '0;
    assign prod     = PROD_W'(samp_use) * PROD_W'(coef_rd);
    assign prod_ext = ACC_BITS'(prod);
    assign rsum     = acc_q + RND_HALF;
    assign rshift   = rsum >>> (COEF_BITS - 1);

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        phase_d    = phase_q;
        fill_d     = fill_q;
        nvalid_d   = nvalid_q;
        base_d     = base_q;
        k_d        = k_q;
        acc_d      = acc_q;
        rnd_d      = rnd_q;
        x_out_d    = x_out_q;
        out_tick_d = 1'b0;
        overrun_d  = overrun_q;

        if (in_tick) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            phase_d  = trig ? '0 : phase_q + PHW'(1);
            fill_d   = (fill_q == FW'(TAPS)) ? fill_q : fill_q + FW'(1);
        end

        if (trig && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    base_d   = wr_ptr_q;
                    nvalid_d = fill_d;
                    k_d      = '0;
                    acc_d    = '0;
                    state_d  = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + prod_ext;
                k_d   = k_q + KW'(1);
                if (k_q == KW'(TAPS - 1)) begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                rnd_d   = BITS'(saturate(64'(rshift), BITS));
                state_d = ST_OUT;
            end
            default: begin
                x_out_d    = rnd_q;
                out_tick_d = 1'b1;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            phase_q    <= '0;
            fill_q     <= '0;
            nvalid_q   <= '0;
            base_q     <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            rnd_q      <= '0;
            x_out_q    <= '0;
            out_tick_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            phase_q    <= phase_d;
            fill_q     <= fill_d;
            nvalid_q   <= nvalid_d;
            base_q     <= base_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            rnd_q      <= rnd_d;
            x_out_q    <= x_out_d;
            out_tick_q <= out_tick_d;
            overrun_q  <= overrun_d;
        end
    end

    assign x_out    = x_out_q;
    assign out_tick = out_tick_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Self-checking bench for cic_comp_fir against a direct-form convolution model.
module tb_cic_comp_fir;
    import cic_comp_pkg::*;

    localparam int TAPS  = 32;
    localparam int DECIM = 2;
    localparam int LAT   = TAPS + 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] x_in = '0;
    logic               in_tick = 1'b0;
    logic signed [15:0] x_out;
    logic               out_tick;
    logic               overrun;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state
    logic signed [15:0] hist[$];
    int                 n_in = 0;
    int                 last_acc = -1;
    logic               ovr_exp = 1'b0;
    int                 exp_q[$];

    // Observed outputs
    int   obs_q[$];
    int   obs_cyc_q[$];
    int   dbl = 0;
    logic prev_tick = 1'b0;

    cic_comp_fir #(
        .BITS(16), .TAPS(TAPS), .COEF_BITS(16), .ACC_BITS(40), .DECIM(DECIM)
    ) dut (
        .CLK(clk), .RST(rst), .x_in(x_in), .in_tick(in_tick),
        .x_out(x_out), .out_tick(out_tick), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_tick) begin
            obs_q.push_back(int'(x_out));
            obs_cyc_q.push_back(cyc);
        end
        if (out_tick && prev_tick) dbl++;
        prev_tick = out_tick;
    end

    // y = sat(round(sum_k x[n-k]*c[k] / 2^15)), samples before reset are zero
    function automatic int model_y();
        longint acc;
        int     n;
        acc = 0;
        n = hist.size();
        for (int k = 0; k < TAPS; k++) begin
            if (k < n) acc += longint'(hist[n-1-k]) * longint'(COEFS[k]);
        end
        acc = (acc + 64'sd16384) >>> 15;
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    function automatic void model_clear();
        hist.delete();
        exp_q.delete();
        n_in = 0;
        last_acc = -1;
        ovr_exp = 1'b0;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_in(input int s);
        x_in = 16'(s);
        in_tick = 1'b1;
        hist.push_back(16'(s));
        n_in++;
        if (n_in % DECIM == 0) begin
            if (last_acc < 0 || (cyc - last_acc) >= TAPS + 4) begin
                exp_q.push_back(model_y());
                last_acc = cyc;
            end else begin
                ovr_exp = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        in_tick = 1'b0;
        x_in = '0;
    endtask

    task automatic do_reset(input bit with_tick);
        rst = 1'b1;
        if (with_tick) begin
            in_tick = 1'b1;
            x_in = 16'sd30000;
        end
        @(posedge clk);
        #1;
        in_tick = 1'b0;
        x_in = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        obs_q.delete();
        obs_cyc_q.delete();
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        checks++;
        if (x_out !== 16'sd0) begin failures++; $display("FAIL reset_x_out got=%0d want=0", x_out); end
        checks++;
        if (out_tick !== 1'b0) begin failures++; $display("FAIL reset_out_tick got=%b want=0", out_tick); end
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b want=0", overrun); end
        tick_in(int'($urandom_range(0, 20000)));
        idle(40);
        tick_in(int'($urandom_range(0, 20000)) - 10000);
        idle(45);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rst_tick_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rst_tick_y[%0d] got=%0d want=%0d", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_latency();
        int c0;
        do_reset(1'b0);
        tick_in(int'($urandom_range(0, 30000)));
        idle(40);
        c0 = cyc;
        tick_in(int'($urandom_range(0, 30000)));
        for (int i = 0; i < 100; i++) begin
            if (obs_q.size() != 0) break;
            @(posedge clk);
            #1;
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL latency_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end else begin
            checks++;
            if (obs_cyc_q[0] - c0 != LAT) begin failures++; $display("FAIL latency got=%0d want=%0d", obs_cyc_q[0] - c0, LAT); end
            checks++;
            if (obs_q[0] !== exp_q[0]) begin failures++; $display("FAIL latency_y got=%0d want=%0d", obs_q[0], exp_q[0]); end
        end
        idle(5);
    endtask

    task automatic test_dc(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick_in(1000);
            idle(39);
        end
        idle(10);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL %s_count got=%0d want=%0d", tag, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL %s_y[%0d] got=%0d want=%0d", tag, i, obs_q[i], exp_q[i]); end
            if (i >= TAPS / DECIM) begin
                checks++;
                if (obs_q[i] < 999 || obs_q[i] > 1001) begin failures++; $display("FAIL %s_gain[%0d] got=%0d want=1000+-1", tag, i, obs_q[i]); end
            end
        end
    endtask

    task automatic test_random();
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            tick_in(int'($signed(16'($urandom))));
            idle(int'($urandom_range(36, 60)));
        end
        idle(10);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL random_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL random_y[%0d] got=%0d want=%0d", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_impulse();
        do_reset(1'b0);
        tick_in(16384);
        idle(39);
        for (int i = 0; i < 2 * TAPS; i++) begin
            tick_in(0);
            idle(39);
        end
        idle(10);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL impulse_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL impulse_y[%0d] got=%0d want=%0d", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_saturation();
        int mx;
        do_reset(1'b0);
        for (int i = 0; i < 40; i++) begin tick_in(-32768); idle(39); end
        for (int i = 0; i < 40; i++) begin tick_in(32767); idle(39); end
        idle(10);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL sat_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        mx = -40000;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL sat_y[%0d] got=%0d want=%0d", i, obs_q[i], exp_q[i]); end
            if (obs_q[i] > mx) mx = obs_q[i];
        end
        checks++;
        if (mx != 32767) begin failures++; $display("FAIL sat_clamp got=%0d want=32767", mx); end
    endtask

    task automatic test_overrun();
        do_reset(1'b0);
        tick_in(int'($urandom_range(0, 20000)));
        idle(3);
        tick_in(int'($urandom_range(0, 20000)));
        idle(3);
        tick_in(int'($urandom_range(0, 20000)));
        idle(5);
        tick_in(int'($urandom_range(0, 20000)));
        idle(60);
        checks++;
        if (overrun !== ovr_exp) begin failures++; $display("FAIL overrun_set got=%b want=%b", overrun, ovr_exp); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL overrun_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        idle(40);
        tick_in(int'($urandom_range(0, 30000)) - 15000);
        idle(40);
        tick_in(int'($urandom_range(0, 30000)) - 15000);
        idle(50);
        checks++;
        if (overrun !== ovr_exp) begin failures++; $display("FAIL overrun_held got=%b want=%b", overrun, ovr_exp); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL overrun_next_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL overrun_y[%0d] got=%0d want=%0d", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_mac();
        obs_q.delete();
        exp_q.delete();
        tick_in(int'($urandom_range(1000, 20000)));
        idle(40);
        tick_in(int'($urandom_range(1000, 20000)));
        idle(4);
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(60);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL midmac_ticks got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        checks++;
        if (x_out !== 16'sd0) begin failures++; $display("FAIL midmac_x_out got=%0d want=0", x_out); end
        checks++;
        if (overrun !== ovr_exp) begin failures++; $display("FAIL midmac_overrun got=%b want=%b", overrun, ovr_exp); end
        obs_q.delete();
        test_dc(2 * TAPS, "dc_after_rst");
    endtask

    task automatic test_no_double_tick();
        checks++;
        if (dbl != 0) begin failures++; $display("FAIL double_tick got=%0d want=0", dbl); end
    endtask

    initial begin
        idle(2);
        test_reset();
        test_latency();
        test_random();
        do_reset(1'b0);
        test_dc(3 * TAPS, "dc");
        test_impulse();
        test_saturation();
        test_overrun();
        test_reset_mid_mac();
        test_no_double_tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cic_comp_fir.md
# cic_comp_fir

Decimate-by-2 CIC compensation FIR that sits directly downstream of the 5-stage CIC decimator. It consumes the CIC's 16-bit sample/tick stream, flattens the CIC sinc^5 passband droop, applies anti-alias filtering, and halves the rate. A single time-shared multiply-accumulate does the arithmetic, which is cheap because CIC output ticks are thousands of clocks apart. Output feeds the AM envelope/audio stage using the same sample/tick convention.

## Interface
- BITS, 16: input/output sample width, signed.
- TAPS, 32: FIR length; power of 2, ≥ 8.
- COEF_BITS, 16: signed coefficient width, Q1.(COEF_BITS-1).
- ACC_BITS, 40: accumulator width; must be ≥ BITS + COEF_BITS + log2(TAPS).
- DECIM, 2: output decimation factor.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset. Synchronous, active-high. One clock domain.
- x_in  in  BITS  signed sample from the CIC; valid when in_tick=1.
- in_tick  in  1  one-cycle strobe marking a new input sample.
- x_out  out  BITS  signed filtered sample; held between ticks.
- out_tick  out  1  one-cycle strobe when x_out updates.
- overrun  out  1  sticky flag: a compute trigger arrived while the MAC was busy.

## Operation
- Sample buffer: 2*TAPS entries, circular, written at wr_ptr on every in_tick, regardless of FSM state. wr_ptr increments and wraps mod 2*TAPS. The 2x depth keeps an in-flight computation from reading overwritten data.
- Phase counter: 0..DECIM-1, advances on each in_tick. The trigger fires on the in_tick where phase == DECIM-1; phase then returns to 0. The first output follows the DECIM-th input after reset.
- FSM states:
  - IDLE → MAC on trigger. Latch base = pointer of the triggering sample and clear acc.
  - MAC: TAPS cycles, k = 0..TAPS-1. acc += buf[base-k] * coef[k]. k is registered. A pipeline register between multiply and add is allowed, at +1 cycle latency.
  - ROUND: acc + 2^(COEF_BITS-2), arithmetic shift right by COEF_BITS-1, saturate to [-2^(BITS-1), 2^(BITS-1)-1].
  - OUT: load x_out, pulse out_tick, → IDLE.
- Coefficients: fixed symmetric set from the package. The sum of coefficients equals 2^(COEF_BITS-1), giving unity DC gain.
- A trigger while not in IDLE: sample is still written, the trigger is dropped, overrun is set to 1. overrun clears only on RST.
- Arithmetic: all signed; products are full width BITS+COEF_BITS, sign-extended to ACC_BITS. No intermediate truncation.

## Timing
- Reset values: x_out=0, out_tick=0, overrun=0, FSM=IDLE, wr_ptr=0, phase=0, acc=0. Buffer contents are zeroed by a reset-time clear or masked by a fill counter; either way, outputs before the buffer fills behave as if prior samples were 0.
- Latency: out_tick asserts exactly TAPS+3 cycles after the triggering in_tick (+1 if the multiplier is pipelined; this is fixed per build and documented in the header).
- Minimum in_tick spacing for loss-free operation: TAPS+4 cycles.
- RST asserted mid-MAC: the computation is abandoned, no out_tick is produced, and all state returns to reset values on the next edge.
- in_tick and RST in the same cycle: RST wins and the sample is discarded.
- out_tick is never asserted for two consecutive cycles.

## Structure
- Package cic_comp_pkg:
  - TAPS_DEFAULT, COEF_BITS_DEFAULT.
  - The coefficient constant array, generated offline as a CIC^5 inverse-sinc compensator with cutoff 0.2·fs_in.
  - An FSM state enum {IDLE, MAC, ROUND, OUT}.
  - A saturate helper function.
- Sub-module fir_coef_rom: synchronous-read ROM indexed by k, mapping to block RAM/LUT. The sample buffer is inferred as a simple dual-port RAM in the top level.

## Test plan
- DC: x_in=1000 on every tick (spacing 5000 clocks) for 3·TAPS inputs → after TAPS inputs, every x_out = 1000 ±1. out_tick occurs on every 2nd input.
- Impulse: single x_in=16384, then zeros → the sequence of outputs equals round(coef[k]/2) for k of the decimation phase, then 0.
- Saturation: step from -32768 to +32767 → no output wraps sign; overshoot samples clamp to 32767 exactly.
- Overrun: two triggers 10 cycles apart → one out_tick, overrun=1 and held; the next properly spaced trigger still yields a correct output.
- Latency: measure in_tick→out_tick = TAPS+3 (35 for default) cycles.
- Reset mid-MAC: RST pulsed at MAC cycle 5 → no out_tick, x_out=0, overrun=0; the next DC run reproduces the DC result.
